// File: rtl/keypad_scanner.sv
// 4x4 (parameterisable) key matrix scanner: column strobe, row synchronizer,
// whole-scan debounce and one-cycle key_in strobe with binary row/col index.
module keypad_scanner #(
  parameter int KEY_ROW  = 4,
  parameter int KEY_COL  = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_ROW-1:0] row_sense,
  output logic [KEY_COL-1:0] col_drive,
  output logic [KEY_ROW-1:0] row,
  output logic [KEY_COL-1:0] col,
  output logic               key_in
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (KEY_COL > 1) ? $clog2(KEY_COL) : 1;
  localparam int SW = 4;

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_ONE   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [KEY_ROW-1:0] sync1, sync2;
  logic [DW-1:0]      dwell;
  logic [CW-1:0]      ci, ci_next;
  logic [0:0]         state;
  logic [1:0]         acc_hits, prev_res;
  logic [KEY_ROW-1:0] acc_r, prev_r;
  logic [KEY_COL-1:0] acc_c, prev_c;
  logic [SW-1:0]      stab;

  logic               sample, scan_end, res_same, stable;
  logic [1:0]         col_hits, hits_next;
  logic [KEY_ROW-1:0] low_row, res_r;
  logic [KEY_COL-1:0] res_c;
  logic [SW-1:0]      stab_next;

  assign sample   = (dwell == DW'(SCAN_DIV - 1));
  assign scan_end = sample && (ci == CW'(KEY_COL - 1));
  assign ci_next  = (ci == CW'(KEY_COL - 1)) ? '0 : ci + CW'(1);

  // Per-column hit count saturates at 2; descending loop leaves the lowest set row.
  always_comb begin
    col_hits = '0;
    low_row  = '0;
    for (int unsigned i = KEY_ROW; i > 0; i--) begin
      if (sync2[i-1]) begin
        low_row = KEY_ROW'(i - 1);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  always_comb begin
    hits_next = acc_hits | col_hits;
    if (acc_hits == 2'd2 || col_hits == 2'd2 || (acc_hits == 2'd1 && col_hits == 2'd1))
      hits_next = RES_MULTI;
    res_r = acc_r;
    res_c = acc_c;
    if (acc_hits == 2'd0 && col_hits != 2'd0) begin
      res_r = low_row;
      res_c = KEY_COL'(ci);
    end
    res_same  = (hits_next == prev_res) &&
                (hits_next != RES_ONE || (res_r == prev_r && res_c == prev_c));
    stab_next = SW'(1);
    if (res_same) stab_next = (stab == SW'(DEBOUNCE)) ? stab : stab + SW'(1);
    stable = (stab_next == SW'(DEBOUNCE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      dwell     <= '0;
      ci        <= '0;
      col_drive <= KEY_COL'(1);
      state     <= IDLE;
      acc_hits  <= '0;
      acc_r     <= '0;
      acc_c     <= '0;
      prev_res  <= RES_NONE;
      prev_r    <= '0;
      prev_c    <= '0;
      stab      <= '0;
      row       <= '0;
      col       <= '0;
      key_in    <= 1'b0;
    end else begin
      sync1  <= row_sense;
      sync2  <= sync1;
      key_in <= 1'b0;
      if (sample) begin
        dwell     <= '0;
        ci        <= ci_next;
        col_drive <= KEY_COL'(1) << ci_next;
      end else begin
        dwell <= dwell + DW'(1);
      end
      if (scan_end) begin
        acc_hits <= '0;
        acc_r    <= '0;
        acc_c    <= '0;
        prev_res <= hits_next;
        prev_r   <= res_r;
        prev_c   <= res_c;
        stab     <= stab_next;
        case (state)
          IDLE: begin
            if (stable && hits_next == RES_ONE) begin
              row    <= res_r;
              col    <= res_c;
              key_in <= 1'b1;
              state  <= HELD;
            end else if (stable && hits_next == RES_MULTI) begin
              row    <= '1;
              col    <= '1;
              key_in <= 1'b1;
              state  <= HELD;
            end
          end
          default: begin
            if (stable && hits_next == RES_NONE) state <= IDLE;
          end
        endcase
      end else if (sample) begin
        acc_hits <= hits_next;
        acc_r    <= res_r;
        acc_c    <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix model driving row_sense, scan-level
// debounce reference model, directed plan followed by randomized key patterns.
module tb_keypad_scanner;
  localparam int SD  = 4;
  localparam int DEB = 2;
  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int T   = NC * SD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] row_sense;
  logic [NC-1:0] col_drive;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic          key_in;

  // bit r*NC+c set = key (r,c) closed
  logic [15:0] pressed = '0;

  int ntests = 0;
  int nfail  = 0;
  int seen   = 0;
  int expn   = 0;

  int         m_kind = 0, m_r = 0, m_c = 0, m_stab = 0;
  bit         m_held = 1'b0, m_pend = 1'b0;
  logic [3:0] m_row = '0, m_col = '0;

  keypad_scanner #(.KEY_ROW(NR), .KEY_COL(NC), .SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_sense (row_sense),
    .col_drive (col_drive),
    .row       (row),
    .col       (col),
    .key_in    (key_in)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_sense = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC+c] && col_drive[c]) row_sense[r] = 1'b1;
  end

  always @(negedge clk) if (key_in === 1'b1) seen++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_r = 0; m_c = 0; m_stab = 0;
    m_held = 1'b0; m_pend = 1'b0;
    m_row = '0; m_col = '0;
  endtask

  // One whole scan seen by the scanner: classify, debounce, accept/release.
  task automatic model_scan(input logic [15:0] pat);
    int  n, kind, r, c;
    bit  same;
    n = $countones(pat);
    kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    r = 0; c = 0;
    for (int i = 0; i < 16; i++) if (pat[i]) begin r = i / NC; c = i % NC; end
    same = (kind == m_kind) && (kind != 1 || (r == m_r && c == m_c));
    m_stab = same ? ((m_stab + 1 > DEB) ? DEB : m_stab + 1) : 1;
    m_kind = kind; m_r = r; m_c = c;
    m_pend = 1'b0;
    if (m_stab == DEB) begin
      if (!m_held && kind == 1) begin
        m_pend = 1'b1; m_row = 4'(r); m_col = 4'(c); m_held = 1'b1; expn++;
      end else if (!m_held && kind == 2) begin
        m_pend = 1'b1; m_row = '1; m_col = '1; m_held = 1'b1; expn++;
      end else if (m_held && kind == 0) begin
        m_held = 1'b0;
      end
    end
  endtask

  // Entered and left at the negedge of the first cycle of a scan.
  task automatic scan(input logic [15:0] pat, input int ncyc);
    pressed = pat;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      check("key_in", {15'b0, key_in}, {15'b0, (cyc == 0) ? m_pend : 1'b0});
      check("row", {12'b0, row}, {12'b0, m_row});
      check("col", {12'b0, col}, {12'b0, m_col});
      check("col_drive", {12'b0, col_drive}, 16'(1) << (cyc / SD));
      @(negedge clk);
    end
    if (ncyc == T) model_scan(pat);
    else m_pend = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst_col_drive", {12'b0, col_drive}, 16'h0001);
      check("rst_row", {12'b0, row}, 16'h0000);
      check("rst_col", {12'b0, col}, 16'h0000);
      check("rst_key_in", {15'b0, key_in}, 16'h0000);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic scans(input logic [15:0] pat, input int n);
    repeat (n) scan(pat, T);
  endtask

  initial begin
    logic [15:0] p;
    int a, b;

    do_reset(3);
    scans(16'h0000, 10);

    // single press (2,1)
    scans(16'h0200, 4);
    scans(16'h0000, 3);

    // bounce on (0,3)
    scan(16'h0008, T); scan(16'h0000, T); scan(16'h0008, T);
    scans(16'h0008, 3);
    scans(16'h0000, 3);

    // multi-press (1,0)+(3,2), then release (1,0) only
    scans(16'h4010, 3);
    scans(16'h4000, 3);
    scans(16'h0000, 3);

    // roll-over (0,0) -> (1,1), release, (1,1) again
    scans(16'h0001, 3);
    scans(16'h0020, 3);
    scans(16'h0000, 2);
    scans(16'h0020, 3);
    scans(16'h0000, 2);

    // reset mid-scan while held
    scans(16'h0200, 3);
    scan(16'h0200, 7);
    do_reset(2);
    scans(16'h0200, 4);
    scans(16'h0000, 3);

    // randomized patterns: none, one key, two keys, held 1..3 scans
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: p = '0;
        1: p = 16'(1) << $urandom_range(0, 15);
        default: begin
          a = int'($urandom_range(0, 15));
          b = int'($urandom_range(0, 15));
          if (b == a) b = (a + 1) % 16;
          p = (16'(1) << a) | (16'(1) << b);
        end
      endcase
      scans(p, int'($urandom_range(1, 3)));
    end
    scans(16'h0000, 3);

    check("strobe_count", 16'(seen), 16'(expn));
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
